// File: rtl/dice_race_pkg.sv
// Shared types and constants for the dice-race game controller and board preview logic.
package dice_race_pkg;

  localparam int TILE_W = 4;
  localparam int DICE_W = 3;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DICE = 3'd1,
    NOTIFY    = 3'd2,
    WAIT_DONE = 3'd3,
    WIN       = 3'd4
  } turn_state_e;

endpackage

// File: rtl/tile_step_adder.sv
// Combinational tile step: pos + dice_value, clamped to the finish tile NUM_TILES-1.
module tile_step_adder
  import dice_race_pkg::*;
#(
  parameter int NUM_TILES = 16
) (
  input  logic [TILE_W-1:0] pos,
  input  logic [DICE_W-1:0] dice_value,
  output logic [TILE_W-1:0] next_pos
);

  localparam logic [TILE_W:0] FINISH = (TILE_W + 1)'(NUM_TILES - 1);

  logic [TILE_W:0] sum;

  // One bit wider than a tile index so the sum cannot wrap before clamping.
  assign sum      = {1'b0, pos} + {{(TILE_W + 1 - DICE_W){1'b0}}, dice_value};
  assign next_pos = (sum > FINISH) ? FINISH[TILE_W-1:0] : sum[TILE_W-1:0];

endmodule

// File: rtl/dice_race_turn_controller.sv
// Two-player dice-race turn controller: accepts rolls, publishes positions, waits for the renderer.
// Optional renderer-acknowledge timeout is built when TURN_TIMEOUT_EN is defined.
module dice_race_turn_controller
  import dice_race_pkg::*;
#(
  parameter int NUM_TILES      = 16,
  parameter int DICE_MAX       = 6,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              game_start,
  input  logic              dice_valid,
  input  logic [DICE_W-1:0] dice_value,
  output logic              dice_ready,
  output logic [TILE_W-1:0] p1_pos,
  output logic [TILE_W-1:0] p2_pos,
  output logic              pos_valid,
  output logic              turn,
  input  logic              turn_done,
  output logic              winner_valid,
  output logic              winner,
  output logic              game_active
);

  localparam logic [TILE_W-1:0] FINISH = TILE_W'(NUM_TILES - 1);
  localparam logic [DICE_W-1:0] DMAX   = DICE_W'(DICE_MAX);

  turn_state_e       state, state_nxt;
  logic [TILE_W-1:0] p1_nxt, p2_nxt, active_pos, step_pos;
  logic              turn_nxt, winner_nxt;
  logic              accept, done, timeout_hit;

  assign active_pos = (turn == PLAYER1) ? p1_pos : p2_pos;
  assign accept     = (state == WAIT_DICE) && dice_valid && dice_ready &&
                      (dice_value != '0) && (dice_value <= DMAX);

  tile_step_adder #(.NUM_TILES(NUM_TILES)) u_step (
    .pos        (active_pos),
    .dice_value (dice_value),
    .next_pos   (step_pos)
  );

`ifdef TURN_TIMEOUT_EN
  localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYCLES - 1);
  logic [25:0] to_cnt;

  // Cleared while in NOTIFY so the first WAIT_DONE cycle starts from zero.
  always_ff @(posedge clk) begin
    if (reset || state == NOTIFY) to_cnt <= '0;
    else if (state == WAIT_DONE && to_cnt != '1) to_cnt <= to_cnt + 26'd1;
  end

  assign timeout_hit = (state == WAIT_DONE) && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign done = turn_done || timeout_hit;

  always_comb begin
    state_nxt  = state;
    p1_nxt     = p1_pos;
    p2_nxt     = p2_pos;
    turn_nxt   = turn;
    winner_nxt = winner;
    case (state)
      IDLE, WIN: begin
        if (game_start) begin
          state_nxt = WAIT_DICE;
          p1_nxt    = '0;
          p2_nxt    = '0;
          turn_nxt  = PLAYER1;
        end
      end
      WAIT_DICE: begin
        if (accept) begin
          if (turn == PLAYER1) p1_nxt = step_pos;
          else                 p2_nxt = step_pos;
          state_nxt = NOTIFY;
        end
      end
      NOTIFY, WAIT_DONE: begin
        if (done) begin
          if (active_pos == FINISH) begin
            state_nxt  = WIN;
            winner_nxt = turn;
          end else begin
            state_nxt = WAIT_DICE;
            turn_nxt  = ~turn;
          end
        end else begin
          state_nxt = WAIT_DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      p1_pos       <= '0;
      p2_pos       <= '0;
      turn         <= PLAYER1;
      winner       <= 1'b0;
      pos_valid    <= 1'b0;
      dice_ready   <= 1'b0;
      winner_valid <= 1'b0;
      game_active  <= 1'b0;
    end else begin
      state        <= state_nxt;
      p1_pos       <= p1_nxt;
      p2_pos       <= p2_nxt;
      turn         <= turn_nxt;
      winner       <= winner_nxt;
      pos_valid    <= (state_nxt == NOTIFY);
      dice_ready   <= (state_nxt == WAIT_DICE);
      winner_valid <= (state_nxt == WIN);
      game_active  <= (state_nxt != IDLE) && (state_nxt != WIN);
    end
  end

endmodule

// File: tb/tb_dice_race_turn_controller.sv
// Directed self-checking bench for dice_race_turn_controller.
module tb_dice_race_turn_controller;
  import dice_race_pkg::*;

  logic              clk = 1'b0;
  logic              reset, game_start, dice_valid, turn_done;
  logic [DICE_W-1:0] dice_value;
  logic              dice_ready, pos_valid, turn, winner_valid, winner, game_active;
  logic [TILE_W-1:0] p1_pos, p2_pos;

  int checks = 0;
  int errors = 0;

  dice_race_turn_controller #(
    .NUM_TILES(16), .DICE_MAX(6), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .game_start(game_start), .dice_valid(dice_valid),
    .dice_value(dice_value), .dice_ready(dice_ready), .p1_pos(p1_pos), .p2_pos(p2_pos),
    .pos_valid(pos_valid), .turn(turn), .turn_done(turn_done),
    .winner_valid(winner_valid), .winner(winner), .game_active(game_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All outputs packed: {dice_ready,pos_valid,turn,winner_valid,winner,game_active,p1,p2}
  function automatic logic [13:0] outs();
    return {dice_ready, pos_valid, turn, winner_valid, winner, game_active, p1_pos, p2_pos};
  endfunction

  task automatic do_move(input logic [2:0] v, input logic [3:0] exp_pos);
    dice_valid = 1'b1; dice_value = v;
    tick();
    dice_valid = 1'b0;
    checks++;
    if (pos_valid !== 1'b1 || (turn ? p2_pos : p1_pos) !== exp_pos) begin
      errors++;
      $display("FAIL move_roll%0d got pos_valid=%b pos=%0d exp pos_valid=1 pos=%0d",
               v, pos_valid, (turn ? p2_pos : p1_pos), exp_pos);
    end
    turn_done = 1'b1;
    tick();
    turn_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; game_start = 0; dice_valid = 0; dice_value = 0; turn_done = 0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (outs() !== 14'd0) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", outs(), 14'd0);
    end
  endtask

  task automatic test_first_roll();
    int pulses;
    game_start = 1'b1; tick(); game_start = 1'b0;
    checks++;
    if (dice_ready !== 1'b1 || game_active !== 1'b1) begin
      errors++; $display("FAIL start got ready=%b active=%b exp 1 1", dice_ready, game_active);
    end
    dice_valid = 1'b1; dice_value = 3'd3;
    tick();
    dice_valid = 1'b0;
    checks++;
    if (p1_pos !== 4'd3 || pos_valid !== 1'b1 || dice_ready !== 1'b0) begin
      errors++; $display("FAIL roll3 got p1=%0d pv=%b rdy=%b exp 3 1 0", p1_pos, pos_valid, dice_ready);
    end
    pulses = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pos_valid) pulses++;
    end
    checks++;
    if (pulses !== 1 || turn !== 1'b0) begin
      errors++; $display("FAIL single_pulse got pulses=%0d turn=%b exp 1 0", pulses, turn);
    end
    turn_done = 1'b1; tick(); turn_done = 1'b0;
    checks++;
    if (turn !== 1'b1 || dice_ready !== 1'b1 || p2_pos !== 4'd0 || p1_pos !== 4'd3) begin
      errors++; $display("FAIL handover got turn=%b rdy=%b p1=%0d p2=%0d exp 1 1 3 0",
                         turn, dice_ready, p1_pos, p2_pos);
    end
  endtask

  task automatic test_bad_dice();
    logic [2:0] bad [2];
    bad[0] = 3'd0; bad[1] = 3'd7;
    for (int i = 0; i < 2; i++) begin
      dice_valid = 1'b1; dice_value = bad[i];
      tick();
      checks++;
      if (dice_ready !== 1'b1 || pos_valid !== 1'b0 || p2_pos !== 4'd0 || turn !== 1'b1) begin
        errors++; $display("FAIL bad_dice_%0d got rdy=%b pv=%b p2=%0d exp 1 0 0", bad[i],
                           dice_ready, pos_valid, p2_pos);
      end
    end
    dice_value = 3'd2;
    tick();
    dice_valid = 1'b0;
    checks++;
    if (p2_pos !== 4'd2 || pos_valid !== 1'b1) begin
      errors++; $display("FAIL good_after_bad got p2=%0d pv=%b exp 2 1", p2_pos, pos_valid);
    end
  endtask

  task automatic test_ignored_events();
    tick();
    game_start = 1'b1; tick(); game_start = 1'b0;
    checks++;
    if (outs() !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2}) begin
      errors++; $display("FAIL start_mid_turn got %b", outs());
    end
    turn_done = 1'b1; tick(); turn_done = 1'b0;
    checks++;
    if (turn !== 1'b0 || dice_ready !== 1'b1) begin
      errors++; $display("FAIL done_after_start got turn=%b rdy=%b exp 0 1", turn, dice_ready);
    end
    turn_done = 1'b1; tick(); turn_done = 1'b0;
    checks++;
    if (turn !== 1'b0 || dice_ready !== 1'b1 || pos_valid !== 1'b0) begin
      errors++; $display("FAIL done_in_wait_dice got turn=%b rdy=%b pv=%b exp 0 1 0",
                         turn, dice_ready, pos_valid);
    end
    dice_valid = 1'b1; dice_value = 3'd1; tick(); dice_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (p1_pos !== 4'd4 || turn !== 1'b0 || dice_ready !== 1'b0 || game_active !== 1'b1) begin
      errors++; $display("FAIL wait_done_hold got p1=%0d turn=%b rdy=%b exp 4 0 0",
                         p1_pos, turn, dice_ready);
    end
    turn_done = 1'b1; tick(); turn_done = 1'b0;
    checks++;
    if (turn !== 1'b1 || dice_ready !== 1'b1) begin
      errors++; $display("FAIL real_done got turn=%b rdy=%b exp 1 1", turn, dice_ready);
    end
  endtask

  task automatic test_win();
    do_move(3'd1, 4'd3);
    do_move(3'd6, 4'd10);
    do_move(3'd1, 4'd4);
    do_move(3'd3, 4'd13);
    do_move(3'd1, 4'd5);
    checks++;
    if (p1_pos !== 4'd13 || turn !== 1'b0 || dice_ready !== 1'b1) begin
      errors++; $display("FAIL back_to_back got p1=%0d turn=%b rdy=%b exp 13 0 1",
                         p1_pos, turn, dice_ready);
    end
    dice_valid = 1'b1; dice_value = 3'd6; tick(); dice_valid = 1'b0;
    checks++;
    if (p1_pos !== 4'd15 || pos_valid !== 1'b1) begin
      errors++; $display("FAIL clamp got p1=%0d pv=%b exp 15 1", p1_pos, pos_valid);
    end
    tick(); tick();
    turn_done = 1'b1; tick(); turn_done = 1'b0;
    checks++;
    if (winner_valid !== 1'b1 || winner !== 1'b0 || turn !== 1'b0 ||
        dice_ready !== 1'b0 || game_active !== 1'b0) begin
      errors++; $display("FAIL win got wv=%b w=%b turn=%b rdy=%b act=%b exp 1 0 0 0 0",
                         winner_valid, winner, turn, dice_ready, game_active);
    end
    dice_valid = 1'b1; dice_value = 3'd2; tick(); tick(); dice_valid = 1'b0;
    checks++;
    if (winner_valid !== 1'b1 || p1_pos !== 4'd15 || p2_pos !== 4'd5 || pos_valid !== 1'b0) begin
      errors++; $display("FAIL win_hold got wv=%b p1=%0d p2=%0d exp 1 15 5", winner_valid,
                         p1_pos, p2_pos);
    end
    game_start = 1'b1; tick(); game_start = 1'b0;
    checks++;
    if (outs() !== {1'b1, 1'b0, 1'b0, 1'b0, winner, 1'b1, 4'd0, 4'd0} || winner_valid !== 1'b0) begin
      errors++; $display("FAIL restart got %b", outs());
    end
  endtask

  task automatic test_reset_mid();
    do_move(3'd1, 4'd1);
    do_move(3'd6, 4'd6);
    do_move(3'd1, 4'd2);
    dice_valid = 1'b1; dice_value = 3'd3; tick(); dice_valid = 1'b0;
    checks++;
    if (p2_pos !== 4'd9 || pos_valid !== 1'b1) begin
      errors++; $display("FAIL p2_at_9 got p2=%0d pv=%b exp 9 1", p2_pos, pos_valid);
    end
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (outs() !== 14'd0) begin
      errors++; $display("FAIL reset_mid got %b exp %b", outs(), 14'd0);
    end
    dice_valid = 1'b1; dice_value = 3'd2;
    tick(); tick();
    checks++;
    if (outs() !== 14'd0) begin
      errors++; $display("FAIL dice_in_idle got %b exp %b", outs(), 14'd0);
    end
    game_start = 1'b1; tick(); game_start = 1'b0;
    checks++;
    if (dice_ready !== 1'b1 || p1_pos !== 4'd0 || pos_valid !== 1'b0) begin
      errors++; $display("FAIL start_with_dice got rdy=%b p1=%0d pv=%b exp 1 0 0",
                         dice_ready, p1_pos, pos_valid);
    end
    tick(); dice_valid = 1'b0;
    checks++;
    if (p1_pos !== 4'd2 || pos_valid !== 1'b1) begin
      errors++; $display("FAIL roll_after_restart got p1=%0d pv=%b exp 2 1", p1_pos, pos_valid);
    end
    turn_done = 1'b1; tick(); turn_done = 1'b0;
  endtask

`ifdef TURN_TIMEOUT_EN
  task automatic test_timeout();
    dice_valid = 1'b1; dice_value = 3'd4; tick(); dice_valid = 1'b0;
    tick();
    for (int i = 0; i < 19; i++) tick();
    checks++;
    if (turn !== 1'b1 || dice_ready !== 1'b0 || p2_pos !== 4'd4) begin
      errors++; $display("FAIL timeout_early got turn=%b rdy=%b p2=%0d exp 1 0 4",
                         turn, dice_ready, p2_pos);
    end
    tick();
    checks++;
    if (turn !== 1'b0 || dice_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_fire got turn=%b rdy=%b exp 0 1", turn, dice_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_roll();
    test_bad_dice();
    test_ignored_events();
    test_win();
    test_reset_mid();
`ifdef TURN_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
